// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in,
// one bit per clock (LSB first), through a single 1-bit full adder.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  // 1-bit full adder used by the serial datapath
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             abort_i,
  input  logic             ack_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_c;

  // Single full adder fed by the current operand bit and the carry flop
  full_adder u_fa (
    .a_i (a_q[cnt_q]),
    .b_i (b_q[cnt_q]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort_i) begin
          // Abort wins over the bit operation; partial result is dropped
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          sum_d   = {fa_s, sum_q[WIDTH-1:1]};
          carry_d = fa_c;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean IDLE
        sum_d   = '0;
        carry_d = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status decoded from the state register; result straight from flops
  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == SHIFT);
  assign done_o  = (state_q == DONE);
  assign sum_o   = sum_q;
  assign cout_o  = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8).

module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         abort_i;
  logic         ack_i;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         cout_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .abort_i (abort_i),
    .ack_i   (ack_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One full transaction: accept, wait for DONE, check result and latency, ack
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] es, input logic ec, input string nm);
    int lat;
    start_i = 1'b1; a_i = a; b_i = b; cin_i = cin;
    tick();
    start_i = 1'b0; a_i = ~a; b_i = ~b; cin_i = ~cin;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL %s accept: busy_o=%b required 1", nm, busy_o);
    end
    lat = 0;
    while (done_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat !== W) begin
      n_err++; $display("FAIL %s latency: got %0d required %0d", nm, lat, W);
    end
    n_cmp++;
    if (sum_o !== es || cout_o !== ec) begin
      n_err++; $display("FAIL %s result: sum=%h cout=%b required sum=%h cout=%b", nm, sum_o, cout_o, es, ec);
    end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b1 || done_o !== 1'b0) begin
      n_err++; $display("FAIL %s after ack: ready=%b done=%b required 1 0", nm, ready_o, done_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b1; a_i = 8'hAA; b_i = 8'h55; cin_i = 1'b1;
    abort_i = 1'b0; ack_i = 1'b0;
    tick(); tick();
    n_cmp++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || sum_o !== 8'h00 || cout_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset: ready=%b busy=%b done=%b sum=%h cout=%b required 1 0 0 00 0",
               ready_o, busy_o, done_o, sum_o, cout_o);
    end
    start_i = 1'b0;
  endtask

  task automatic test_first_start();
    // Start presented on the very edge reset releases
    rst_ni = 1'b1;
    run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "first_start");
  endtask

  task automatic test_hold_and_ack();
    start_i = 1'b1; a_i = 8'h5A; b_i = 8'h3C; cin_i = 1'b0;
    tick();
    start_i = 1'b0;
    repeat (W) tick();
    n_cmp++;
    if (done_o !== 1'b1 || sum_o !== 8'h96 || cout_o !== 1'b0) begin
      n_err++; $display("FAIL hold_entry: done=%b sum=%h cout=%b required 1 96 0", done_o, sum_o, cout_o);
    end
    // start and abort are both ignored while DONE
    start_i = 1'b1; abort_i = 1'b1; a_i = 8'h01; b_i = 8'h01;
    repeat (3) tick();
    abort_i = 1'b0;
    n_cmp++;
    if (done_o !== 1'b1 || sum_o !== 8'h96 || cout_o !== 1'b0 || ready_o !== 1'b0) begin
      n_err++; $display("FAIL hold_stable: done=%b ready=%b sum=%h cout=%b required 1 0 96 0",
                        done_o, ready_o, sum_o, cout_o);
    end
    // ack together with start: only ack takes effect
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0; start_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++; $display("FAIL ack_with_start: ready=%b busy=%b done=%b required 1 0 0", ready_o, busy_o, done_o);
    end
  endtask

  task automatic test_vectors();
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_01");
    run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ff_plus_ff_c1");
    run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "80_plus_80");
    run_add(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, "7f_plus_c1");
    run_add(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, "aa_plus_55");
    run_add(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, "aa_plus_55_c1");
    run_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
  endtask

  task automatic test_ignore_in_shift();
    int lat;
    start_i = 1'b1; a_i = 8'h5A; b_i = 8'h3C; cin_i = 1'b0;
    tick();
    start_i = 1'b0;
    tick();
    // New start, new operands and a stray ack mid-addition
    start_i = 1'b1; a_i = 8'hFF; b_i = 8'hFF; cin_i = 1'b1; ack_i = 1'b1;
    tick();
    start_i = 1'b0; ack_i = 1'b0;
    lat = 2;
    while (done_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat !== W || sum_o !== 8'h96 || cout_o !== 1'b0) begin
      n_err++; $display("FAIL ignore_in_shift: lat=%0d sum=%h cout=%b required %0d 96 0", lat, sum_o, cout_o, W);
    end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic test_abort();
    start_i = 1'b1; a_i = 8'h5A; b_i = 8'h3C; cin_i = 1'b0;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++; $display("FAIL abort: ready=%b busy=%b done=%b required 1 0 0", ready_o, busy_o, done_o);
    end
    repeat (W) tick();
    n_cmp++;
    if (done_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++; $display("FAIL abort_no_done: done=%b ready=%b required 0 1", done_o, ready_o);
    end
    run_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; a_i = 8'h5A; b_i = 8'h3C; cin_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b0;
    tick();
    n_cmp++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || sum_o !== 8'h00 || cout_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: ready=%b busy=%b done=%b sum=%h cout=%b required 1 0 0 00 0",
               ready_o, busy_o, done_o, sum_o, cout_o);
    end
    rst_ni = 1'b1;
    run_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    run_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "b2b_0");
    run_add(8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, "b2b_1");
    n_cmp++;
    if (cyc - c0 !== 2 * (W + 2)) begin
      n_err++; $display("FAIL back_to_back cycles: got %0d required %0d", cyc - c0, 2 * (W + 2));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, es;
    logic         c, ec;
    for (int i = 0; i < 25; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      {ec, es} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      run_add(a, b, c, es, ec, "random");
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_first_start();
    test_hold_and_ack();
    test_vectors();
    test_ignore_in_shift();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request to begin an addition; accepted only when ready_o=1.
REQ-005 SHALL have port a_i  input  WIDTH  operand A, sampled on the accepting edge.
REQ-006 SHALL have port b_i  input  WIDTH  operand B, sampled on the accepting edge.
REQ-007 SHALL have port cin_i  input  1  initial carry, sampled on the accepting edge.
REQ-008 SHALL have port abort_i  input  1  cancel an addition in progress.
REQ-009 SHALL have port ack_i  input  1  consumer acknowledge of a presented result.
REQ-010 SHALL have port ready_o  output  1  high in IDLE only.
REQ-011 SHALL have port busy_o  output  1  high in SHIFT only.
REQ-012 SHALL have port done_o  output  1  high in DONE only; result valid.
REQ-013 SHALL have port sum_o  output  WIDTH  result, valid while done_o=1.
REQ-014 SHALL have port cout_o  output  1  final carry, valid while done_o=1.

Function
REQ-015 SHALL compute sum_o/cout_o = a_i + b_i + cin_i modulo 2^WIDTH / carry-out, one bit per clock, LSB first, via a single 1-bit full adder instance (full_adder) plus an operand shift register, sum shift register, carry flop and bit counter.
REQ-016 SHALL implement a three-state FSM: IDLE, SHIFT, DONE; no other states reachable; illegal encodings SHALL return to IDLE.
REQ-017 IDLE: start_i=1 at an edge SHALL load a_i, b_i, cin_i, clear bit counter to 0, go to SHIFT; start_i=0 SHALL stay in IDLE.
REQ-018 SHIFT: each edge SHALL feed operand bit [counter] and carry flop into the full adder, shift its sum into the sum register MSB (register shifts right), store its carry in the carry flop, increment counter.
REQ-019 SHIFT: on the edge where counter = WIDTH-1, SHALL perform the last bit and go to DONE; done_o therefore rises exactly WIDTH cycles after the accepting edge.
REQ-020 SHIFT: abort_i=1 SHALL take priority over the bit operation, discard partial state and go to IDLE on that edge; abort_i SHALL be ignored in IDLE and DONE.
REQ-021 DONE: sum_o and cout_o SHALL remain stable until ack_i=1 at an edge, which SHALL go to IDLE; ack_i outside DONE SHALL be ignored.
REQ-022 start_i while busy_o=1 or done_o=1 SHALL be ignored (not queued); a_i/b_i/cin_i changes outside the accepting edge SHALL not affect the result.
REQ-023 Simultaneous ack_i and start_i in DONE: only ack_i takes effect; new start accepted no earlier than the following IDLE cycle.
REQ-024 Back-to-back throughput: one result per WIDTH+2 cycles minimum (accept, WIDTH shifts ending in DONE, ack).
REQ-025 Outputs SHALL be registered or decoded from FSM state only; no combinational path from any input to any output.

Reset
REQ-026 rst_ni=0 at an edge SHALL force IDLE from any state, including mid-SHIFT, overriding all other inputs.
REQ-027 Reset values: ready_o=1, busy_o=0, done_o=0, sum_o=0, cout_o=0, counter=0, carry flop=0.
REQ-028 First start_i SHALL be accepted on the first edge with rst_ni=1.

Verification
REQ-029 WIDTH=8, a=0x5A, b=0x3C, cin=0, start -> busy 8 cycles, done_o=1, sum_o=0x96, cout_o=0, held until ack.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum_o=0x00, cout_o=1; a=0xFF, b=0xFF, cin=1 -> sum_o=0xFF, cout_o=1.
REQ-031 Start 0x5A+0x3C, abort_i at 4th SHIFT cycle -> IDLE next cycle, done_o never asserts; next start 0x01+0x02 -> sum_o=0x03, cout_o=0.
REQ-032 rst_ni=0 at 3rd SHIFT cycle -> all outputs at reset values next cycle; fresh 0x10+0x20 -> 0x30.
REQ-033 start_i pulsed with new operands during SHIFT and during DONE (with ack_i same cycle) -> ignored; original result unchanged, ready_o only after ack.
REQ-034 Randomised 1000 additions with WIDTH=8 and WIDTH=3 against a reference model, random ack delay -> all sums/carries match, latency exactly WIDTH.
